// File: rtl/load_store_unit_if.sv
// Execute-side request/response and data-memory req/ack signals of the load/store unit.
// slave is the unit's view; master is the view of whoever drives execute and memory.
interface load_store_unit_if;
    logic        Start;
    logic        MemWrite;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic [2:0]  Funct3;
    logic        MemReq;
    logic        MemWe;
    logic [31:0] MemAddr;
    logic [3:0]  MemWStrb;
    logic [31:0] MemWData;
    logic [31:0] MemRData;
    logic        MemAck;
    logic [31:0] ReadData;
    logic        Done;
    logic        Error;
    logic        Busy;

    modport slave (
        input  Start, MemWrite, ALUResult, WriteData, Funct3, MemRData, MemAck,
        output MemReq, MemWe, MemAddr, MemWStrb, MemWData, ReadData, Done, Error, Busy
    );

    modport master (
        output Start, MemWrite, ALUResult, WriteData, Funct3, MemRData, MemAck,
        input  MemReq, MemWe, MemAddr, MemWStrb, MemWData, ReadData, Done, Error, Busy
    );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store stage: drives a req/ack memory port and returns extended load data.
// Start-to-Done is 2 cycles with no wait states (1 on error); Busy holds upstream until Done.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    load_store_unit_if.slave      bus
);
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t      state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic        mem_req, mem_req_nxt;
    logic        mem_we, mem_we_nxt;
    logic [31:0] mem_addr, mem_addr_nxt;
    logic [3:0]  mem_strb, mem_strb_nxt;
    logic [31:0] mem_wdata, mem_wdata_nxt;
    logic [31:0] read_data, read_data_nxt;
    logic        done, done_nxt;
    logic        error, error_nxt;
    logic        is_load, is_load_nxt;
    logic [2:0]  f3, f3_nxt;
    logic [1:0]  off, off_nxt;

    logic        legal;
    logic        aligned;
    logic [3:0]  st_strb;
    logic [31:0] st_data;
    logic [31:0] lane;
    logic [15:0] half;
    logic [31:0] ld_data;

    // Decode of the incoming request, only meaningful while Start is sampled in IDLE
    always_comb begin
        legal   = 1'b0;
        aligned = 1'b1;
        st_strb = 4'b1111;
        st_data = bus.WriteData;
        if (bus.MemWrite)
            legal = (bus.Funct3 == 3'b000) || (bus.Funct3 == 3'b001) || (bus.Funct3 == 3'b010);
        else
            legal = (bus.Funct3 == 3'b000) || (bus.Funct3 == 3'b001) || (bus.Funct3 == 3'b010) ||
                    (bus.Funct3 == 3'b100) || (bus.Funct3 == 3'b101);
        case (bus.Funct3[1:0])
            2'b00: begin
                st_strb = 4'b0001 << bus.ALUResult[1:0];
                st_data = {4{bus.WriteData[7:0]}};
            end
            2'b01: begin
                aligned = ~bus.ALUResult[0];
                st_strb = bus.ALUResult[1] ? 4'b1100 : 4'b0011;
                st_data = {2{bus.WriteData[15:0]}};
            end
            default: begin
                aligned = (bus.ALUResult[1:0] == 2'b00);
                st_strb = 4'b1111;
                st_data = bus.WriteData;
            end
        endcase
    end

    always_comb begin
        lane = bus.MemRData >> {off, 3'b000};
        half = off[1] ? bus.MemRData[31:16] : bus.MemRData[15:0];
        case (f3)
            3'b000:  ld_data = {{24{lane[7]}}, lane[7:0]};
            3'b001:  ld_data = {{16{half[15]}}, half};
            3'b100:  ld_data = {24'd0, lane[7:0]};
            3'b101:  ld_data = {16'd0, half};
            default: ld_data = bus.MemRData;
        endcase
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        mem_req_nxt   = mem_req;
        mem_we_nxt    = mem_we;
        mem_addr_nxt  = mem_addr;
        mem_strb_nxt  = mem_strb;
        mem_wdata_nxt = mem_wdata;
        read_data_nxt = read_data;
        done_nxt      = done;
        error_nxt     = error;
        is_load_nxt   = is_load;
        f3_nxt        = f3;
        off_nxt       = off;
        case (state)
            IDLE: begin
                if (bus.Start) begin
                    is_load_nxt = ~bus.MemWrite;
                    f3_nxt      = bus.Funct3;
                    off_nxt     = bus.ALUResult[1:0];
                    if (legal && aligned) begin
                        state_nxt     = REQ;
                        cnt_nxt       = '0;
                        mem_req_nxt   = 1'b1;
                        mem_we_nxt    = bus.MemWrite;
                        mem_addr_nxt  = {bus.ALUResult[31:2], 2'b00};
                        mem_strb_nxt  = bus.MemWrite ? st_strb : 4'b0000;
                        mem_wdata_nxt = st_data;
                    end else begin
                        state_nxt = RESP;
                        done_nxt  = 1'b1;
                        error_nxt = 1'b1;
                    end
                end
            end
            REQ: begin
                if (bus.MemAck) begin
                    state_nxt   = RESP;
                    cnt_nxt     = '0;
                    mem_req_nxt = 1'b0;
                    mem_we_nxt  = 1'b0;
                    done_nxt    = 1'b1;
                    error_nxt   = 1'b0;
                    if (is_load)
                        read_data_nxt = ld_data;
                end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_nxt   = RESP;
                    cnt_nxt     = '0;
                    mem_req_nxt = 1'b0;
                    mem_we_nxt  = 1'b0;
                    done_nxt    = 1'b1;
                    error_nxt   = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            RESP: begin
                state_nxt = IDLE;
                done_nxt  = 1'b0;
                error_nxt = 1'b0;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_strb  <= '0;
            mem_wdata <= '0;
            read_data <= '0;
            done      <= 1'b0;
            error     <= 1'b0;
            is_load   <= 1'b0;
            f3        <= '0;
            off       <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            mem_req   <= mem_req_nxt;
            mem_we    <= mem_we_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_strb  <= mem_strb_nxt;
            mem_wdata <= mem_wdata_nxt;
            read_data <= read_data_nxt;
            done      <= done_nxt;
            error     <= error_nxt;
            is_load   <= is_load_nxt;
            f3        <= f3_nxt;
            off       <= off_nxt;
        end
    end

    assign bus.MemReq   = mem_req;
    assign bus.MemWe    = mem_we;
    assign bus.MemAddr  = mem_addr;
    assign bus.MemWStrb = mem_strb;
    assign bus.MemWData = mem_wdata;
    assign bus.ReadData = read_data;
    assign bus.Done     = done;
    assign bus.Error    = error;
    assign bus.Busy     = (state != IDLE);
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: responds as a memory with a programmable ack delay.
module tb_load_store_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    load_store_unit_if bus();

    load_store_unit #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Issues one access and plays memory; waits<0 means never acknowledge.
    task automatic run_access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                              input logic [2:0] f3, input int waits, input logic [31:0] rdata,
                              output int lat, output int req_cyc, output int busy_cyc,
                              output logic err, output logic [31:0] rd,
                              output logic [31:0] a_o, output logic [3:0] s_o,
                              output logic [31:0] d_o, output logic we_o, output logic stable);
        lat = -1; req_cyc = 0; busy_cyc = 0; err = 1'bx; rd = 'x;
        a_o = 'x; s_o = 'x; d_o = 'x; we_o = 1'bx; stable = 1'b1;
        bus.Start = 1'b1; bus.MemWrite = we; bus.ALUResult = addr;
        bus.WriteData = wd; bus.Funct3 = f3; bus.MemAck = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk); #1;
            bus.Start = 1'b0;
            bus.MemAck = 1'b0;
            if (bus.Busy) busy_cyc++;
            if (bus.MemReq) begin
                req_cyc++;
                if (req_cyc == 1) begin
                    a_o = bus.MemAddr; s_o = bus.MemWStrb; d_o = bus.MemWData; we_o = bus.MemWe;
                end else if (a_o !== bus.MemAddr || s_o !== bus.MemWStrb ||
                             d_o !== bus.MemWData || we_o !== bus.MemWe) begin
                    stable = 1'b0;
                end
                bus.MemRData = rdata;
                if (req_cyc - 1 == waits) bus.MemAck = 1'b1;
            end
            if (bus.Done) begin
                lat = i; err = bus.Error; rd = bus.ReadData;
                break;
            end
        end
    endtask

    task automatic test_reset;
        bus.Start = 0; bus.MemWrite = 0; bus.ALUResult = 0; bus.WriteData = 0;
        bus.Funct3 = 0; bus.MemRData = 0; bus.MemAck = 0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({bus.MemReq, bus.MemWe, bus.Done, bus.Error, bus.Busy} !== 5'b0 ||
            bus.MemAddr !== 32'h0 || bus.MemWStrb !== 4'h0 || bus.MemWData !== 32'h0 ||
            bus.ReadData !== 32'h0) begin
            bad++;
            $display("FAIL reset_state got req=%b we=%b done=%b err=%b busy=%b addr=%h strb=%b wd=%h rd=%h want all zero",
                     bus.MemReq, bus.MemWe, bus.Done, bus.Error, bus.Busy, bus.MemAddr,
                     bus.MemWStrb, bus.MemWData, bus.ReadData);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_lw;
        int lat, rc, bc; logic err, we_o, st; logic [31:0] rd, a, d; logic [3:0] s;
        run_access(1'b0, 32'h0000_1000, 32'h0, 3'b010, 0, 32'hDEAD_BEEF,
                   lat, rc, bc, err, rd, a, s, d, we_o, st);
        total++;
        if (a !== 32'h0000_1000 || s !== 4'b0000 || we_o !== 1'b0) begin
            bad++; $display("FAIL lw_req got addr=%h strb=%b we=%b want 00001000 0000 0", a, s, we_o);
        end
        total++;
        if (lat !== 2 || rc !== 1 || err !== 1'b0 || rd !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL lw_done got lat=%0d req=%0d err=%b rd=%h want 2 1 0 deadbeef", lat, rc, err, rd);
        end
        @(posedge clk); #1;
        total++;
        if (bus.Done !== 1'b0 || bus.Busy !== 1'b0) begin
            bad++; $display("FAIL lw_pulse got done=%b busy=%b want 0 0", bus.Done, bus.Busy);
        end
    endtask

    task automatic test_load_extend;
        int lat, rc, bc; logic err, we_o, st; logic [31:0] rd, a, d; logic [3:0] s;
        run_access(1'b0, 32'h0000_1003, 32'h0, 3'b000, 0, 32'h80FF_1234,
                   lat, rc, bc, err, rd, a, s, d, we_o, st);
        total++;
        if (rd !== 32'hFFFF_FF80 || a !== 32'h0000_1000 || lat !== 2) begin
            bad++; $display("FAIL lb got rd=%h addr=%h lat=%0d want ffffff80 00001000 2", rd, a, lat);
        end
        @(posedge clk); #1;
        run_access(1'b0, 32'h0000_1003, 32'h0, 3'b100, 0, 32'h80FF_1234,
                   lat, rc, bc, err, rd, a, s, d, we_o, st);
        total++;
        if (rd !== 32'h0000_0080 || lat !== 2) begin
            bad++; $display("FAIL lbu got rd=%h lat=%0d want 00000080 2", rd, lat);
        end
        @(posedge clk); #1;
        run_access(1'b0, 32'h0000_1002, 32'h0, 3'b001, 0, 32'h80FF_1234,
                   lat, rc, bc, err, rd, a, s, d, we_o, st);
        total++;
        if (rd !== 32'hFFFF_80FF || lat !== 2 || err !== 1'b0) begin
            bad++; $display("FAIL lh got rd=%h lat=%0d err=%b want ffff80ff 2 0", rd, lat, err);
        end
        @(posedge clk); #1;
        run_access(1'b0, 32'h0000_1000, 32'h0, 3'b101, 1, 32'h1234_9ABC,
                   lat, rc, bc, err, rd, a, s, d, we_o, st);
        total++;
        if (rd !== 32'h0000_9ABC || lat !== 3) begin
            bad++; $display("FAIL lhu got rd=%h lat=%0d want 00009abc 3", rd, lat);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_stores;
        int lat, rc, bc; logic err, we_o, st; logic [31:0] rd, a, d; logic [3:0] s;
        run_access(1'b1, 32'h0000_2002, 32'h0000_ABCD, 3'b001, 3, 32'h5555_5555,
                   lat, rc, bc, err, rd, a, s, d, we_o, st);
        total++;
        if (a !== 32'h0000_2000 || s !== 4'b1100 || d !== 32'hABCD_ABCD || we_o !== 1'b1) begin
            bad++; $display("FAIL sh_req got addr=%h strb=%b wd=%h we=%b want 00002000 1100 abcdabcd 1", a, s, d, we_o);
        end
        total++;
        if (rc !== 4 || st !== 1'b1 || lat !== 5 || err !== 1'b0) begin
            bad++; $display("FAIL sh_hold got req_cycles=%0d stable=%b lat=%0d err=%b want 4 1 5 0", rc, st, lat, err);
        end
        total++;
        if (rd !== 32'h0000_9ABC) begin
            bad++; $display("FAIL sh_keeps_rdata got %h want 00009abc", rd);
        end
        @(posedge clk); #1;
        run_access(1'b1, 32'h0000_3001, 32'hFFFF_FF5A, 3'b000, 0, 32'h0,
                   lat, rc, bc, err, rd, a, s, d, we_o, st);
        total++;
        if (a !== 32'h0000_3000 || s !== 4'b0010 || d !== 32'h5A5A_5A5A || lat !== 2) begin
            bad++; $display("FAIL sb got addr=%h strb=%b wd=%h lat=%0d want 00003000 0010 5a5a5a5a 2", a, s, d, lat);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_errors;
        int lat, rc, bc; logic err, we_o, st; logic [31:0] rd, a, d; logic [3:0] s;
        run_access(1'b0, 32'h0000_1002, 32'h0, 3'b010, 0, 32'h0,
                   lat, rc, bc, err, rd, a, s, d, we_o, st);
        total++;
        if (lat !== 1 || rc !== 0 || bc !== 1 || err !== 1'b1) begin
            bad++; $display("FAIL lw_misaligned got lat=%0d req=%0d busy=%0d err=%b want 1 0 1 1", lat, rc, bc, err);
        end
        total++;
        if (rd !== 32'h0000_9ABC) begin
            bad++; $display("FAIL err_keeps_rdata got %h want 00009abc", rd);
        end
        @(posedge clk); #1;
        total++;
        if (bus.Busy !== 1'b0 || bus.Error !== 1'b0 || bus.Done !== 1'b0) begin
            bad++; $display("FAIL err_clear got busy=%b err=%b done=%b want 0 0 0", bus.Busy, bus.Error, bus.Done);
        end
        run_access(1'b1, 32'h0000_2000, 32'h1, 3'b011, 0, 32'h0,
                   lat, rc, bc, err, rd, a, s, d, we_o, st);
        total++;
        if (lat !== 1 || rc !== 0 || bc !== 1 || err !== 1'b1) begin
            bad++; $display("FAIL st_illegal got lat=%0d req=%0d busy=%0d err=%b want 1 0 1 1", lat, rc, bc, err);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_timeout;
        int lat, rc, bc; logic err, we_o, st; logic [31:0] rd, a, d; logic [3:0] s;
        logic seen;
        run_access(1'b0, 32'h0000_4000, 32'h0, 3'b010, -1, 32'h0,
                   lat, rc, bc, err, rd, a, s, d, we_o, st);
        total++;
        if (rc !== 16 || lat !== 17 || err !== 1'b1 || bus.MemReq !== 1'b0) begin
            bad++; $display("FAIL timeout got req_cycles=%0d lat=%0d err=%b req_now=%b want 16 17 1 0", rc, lat, err, bus.MemReq);
        end
        @(posedge clk); #1;
        seen = 1'b0;
        bus.MemRData = 32'hCAFE_F00D;
        bus.MemAck = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            if (bus.Done || bus.MemReq || bus.Busy) seen = 1'b1;
        end
        bus.MemAck = 1'b0;
        total++;
        if (seen !== 1'b0 || bus.ReadData !== 32'h0000_9ABC) begin
            bad++; $display("FAIL late_ack got response=%b rd=%h want 0 00009abc", seen, bus.ReadData);
        end
    endtask

    task automatic test_reset_mid_access;
        int lat, rc, bc; logic err, we_o, st; logic [31:0] rd, a, d; logic [3:0] s;
        logic seen;
        bus.Start = 1'b1; bus.MemWrite = 1'b0; bus.ALUResult = 32'h0000_5000; bus.Funct3 = 3'b010;
        bus.MemAck = 1'b0;
        @(posedge clk); #1;
        bus.Start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (bus.MemReq !== 1'b1) begin
            bad++; $display("FAIL pre_reset_req got %b want 1", bus.MemReq);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (bus.MemReq !== 1'b0 || bus.Busy !== 1'b0 || bus.Done !== 1'b0 || bus.ReadData !== 32'h0) begin
            bad++; $display("FAIL async_reset got req=%b busy=%b done=%b rd=%h want 0 0 0 0",
                            bus.MemReq, bus.Busy, bus.Done, bus.ReadData);
        end
        #2 rst_n = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (bus.Done || bus.MemReq) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++; $display("FAIL reset_no_done got activity=%b want 0", seen);
        end
        run_access(1'b1, 32'h0000_0010, 32'h1234_5678, 3'b010, 0, 32'h0,
                   lat, rc, bc, err, rd, a, s, d, we_o, st);
        total++;
        if (a !== 32'h0000_0010 || s !== 4'b1111 || d !== 32'h1234_5678 || we_o !== 1'b1 ||
            lat !== 2 || err !== 1'b0) begin
            bad++; $display("FAIL sw_after_reset got addr=%h strb=%b wd=%h we=%b lat=%0d err=%b want 00000010 1111 12345678 1 2 0",
                            a, s, d, we_o, lat, err);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_lw();
        test_load_extend();
        test_stores();
        test_errors();
        test_timeout();
        test_reset_mid_access();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory-access stage directly downstream of the ALU. It takes the ALU Result as the effective address for loads and stores. It drives a req/ack data-memory port with byte strobes, then returns sign- or zero-extended load data for writeback. It also asserts Busy so the core control holds the PC while an access is outstanding.

Parameters:
TIMEOUT_CYCLES, 16, number of REQ cycles without MemAck before the access aborts with Error
CNT_W, 5, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
Start  input  1  access request from execute; sampled only in IDLE
MemWrite  input  1  1 = store, 0 = load; captured with Start
ALUResult  input  32  effective address (ALU Result)
WriteData  input  32  store data (rs2)
Funct3  input  3  RV32I width/sign code (LB=000 LH=001 LW=010 LBU=100 LHU=101; SB=000 SH=001 SW=010)
MemReq  output  1  memory request, held until ack or abort
MemWe  output  1  write enable qualifying MemReq
MemAddr  output  32  word-aligned address, {addr[31:2],2'b00}
MemWStrb  output  4  byte strobes; 0000 for loads
MemWData  output  32  lane-replicated store data
MemRData  input  32  read data, valid when MemAck=1
MemAck  input  1  memory completion
ReadData  output  32  extended load data, valid when Done=1 and the access is a load
Done  output  1  one-cycle completion pulse
Error  output  1  valid with Done: misaligned, illegal Funct3, or timeout
Busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE; MemReq, MemWe, Done, Error, Busy = 0; MemAddr, MemWStrb, MemWData, ReadData = 0; timeout counter = 0. Reset asserted mid-access drops MemReq immediately. No Done is produced for the aborted access.
- Everything except Busy is registered. Busy decodes state.
- FSM states: IDLE, REQ, RESP.
- IDLE: on Start=1, capture MemWrite, ALUResult, WriteData and Funct3.
  - Legal and aligned access: go to REQ and assert MemReq/MemWe/MemAddr/MemWStrb/MemWData on the next edge.
  - Illegal or misaligned access: go to RESP with Error=1; MemReq is never asserted.
- Legality rules:
  - Loads: Funct3 must be in {000,001,010,100,101}.
  - Stores: Funct3 must be in {000,001,010}.
  - Alignment: halfword needs addr[0]=0; word needs addr[1:0]=00.
- REQ: MemReq and all Mem* outputs are held stable. The counter increments each cycle MemAck=0.
  - MemAck=1: capture MemRData, go to RESP with Error=0, clear the counter.
  - Counter reaches TIMEOUT_CYCLES-1 with no ack: go to RESP with Error=1. MemReq deasserts on the same edge.
  - MemAck outside REQ is ignored.
- RESP: Done=1 for exactly one cycle, then IDLE. Start in RESP is ignored; upstream holds Start while Busy=1. Error is cleared on return to IDLE.
- Latency: Start at edge 0, MemReq high after edge 0, earliest ack sampled at edge 1, Done high after edge 1. This gives 2 cycles Start-to-Done with zero memory wait states. An error path takes 1 cycle.
- Store strobes and data:
  - SB: MemWStrb = 0001<<addr[1:0], MemWData = {4{wd[7:0]}}.
  - SH: MemWStrb = addr[1] ? 1100 : 0011, MemWData = {2{wd[15:0]}}.
  - SW: MemWStrb = 1111, MemWData = wd.
- Load extraction: byte lane = MemRData >> (8*addr[1:0]); halfword lane = addr[1] ? [31:16] : [15:0].
  - LB and LH sign-extend.
  - LBU and LHU zero-extend.
  - LW passes data through.
  - ReadData holds its value until the next load completes; stores and errors leave it unchanged.

Test Plan:
- LW, ALUResult=0x00001000, MemRData=0xDEADBEEF, ack on first REQ cycle -> MemAddr=0x00001000, MemWStrb=0000; Done two cycles after Start; ReadData=0xDEADBEEF; Error=0.
- LB at 0x00001003, MemRData=0x80FF1234, then LBU at the same address -> ReadData=0xFFFFFF80 then 0x00000080; LH at 0x1002 -> 0xFFFF80FF.
- SH at 0x00002002, WriteData=0x0000ABCD, ack after 3 wait cycles -> MemAddr=0x2000, MemWStrb=1100, MemWData=0xABCDABCD, MemWe=1 held for 4 cycles; Done=1 with Error=0.
- LW at 0x00001002 and store with Funct3=011 -> no MemReq; Done one cycle after Start with Error=1; Busy=1 for exactly one cycle.
- Load with MemAck held 0 -> MemReq high for exactly TIMEOUT_CYCLES=16 cycles, then Done=1 with Error=1; a late MemAck in IDLE causes no response.
- rst_n pulled low during REQ -> MemReq and Busy drop asynchronously, no Done; a subsequent SW to 0x10 with WriteData=0x12345678 completes normally with MemWStrb=1111 and MemWData=0x12345678.
